// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants for the UART receive controller: controller
//            state encoding, FIFO entry layout and a ceil-log2 helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // FIFO entry layout: {flags, data}, flags = {stop_err, parity_err}
    localparam int DATA_W  = 8;
    localparam int FLAG_W  = 2;
    localparam int ENTRY_W = DATA_W + FLAG_W;

    // Controller state encoding
    localparam logic [1:0] c_ST_OFF    = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_BREAK  = 2'd2;

    // Smallest r such that 2**r >= value (0 for value <= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Synchronous FIFO for received frames. A push into a full FIFO
//            is accepted when a pop happens in the same cycle. The read port
//            shows zero while empty so the head is clean after reset.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [clog2(DEPTH):0] o_level
);

    localparam int               c_AW       = clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL_LVL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_level;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_FULL_LVL);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents are only observed through the gated read port
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Receive-side controller. Buffers completed frames in a FIFO,
//            keeps saturating error/overrun statistics, detects line breaks
//            and gates intake with rx_en. Presents a valid/ready byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 8,
    parameter int BREAK_CYCLES = 160,
    parameter int DROP_ERR     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_en,
    input  logic                  rx_line,
    input  logic                  frm_valid,
    input  logic [DATA_W-1:0]     frm_data,
    input  logic                  frm_parity_err,
    input  logic                  frm_stop_err,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [FLAG_W-1:0]     out_err,
    input  logic                  out_ready,
    input  logic                  clr_stats,
    output logic [clog2(DEPTH):0] fifo_level,
    output logic                  overrun,
    output logic                  break_det,
    output logic [CNT_W-1:0]      parity_err_cnt,
    output logic [CNT_W-1:0]      stop_err_cnt,
    output logic [CNT_W-1:0]      overrun_cnt
);

    localparam int                 c_TMR_W   = clog2(BREAK_CYCLES + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(BREAK_CYCLES);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_tmr;
    logic               r_break_det;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_pe_cnt;
    logic [CNT_W-1:0]   r_se_cnt;
    logic [CNT_W-1:0]   r_ov_cnt;

    logic               w_accept;
    logic               w_has_err;
    logic               w_store;
    logic [FLAG_W-1:0]  w_wflags;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_lost;
    logic [ENTRY_W-1:0] w_rdata;

    // Next-state logic; disabling always wins over break entry/exit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_OFF: begin
                if (rx_en) w_state_nxt = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if (!rx_en)                  w_state_nxt = c_ST_OFF;
                else if (r_tmr == c_TMR_MAX) w_state_nxt = c_ST_BREAK;
            end
            c_ST_BREAK: begin
                if (!rx_en)       w_state_nxt = c_ST_OFF;
                else if (rx_line) w_state_nxt = c_ST_ACTIVE;
            end
            default: w_state_nxt = c_ST_OFF;
        endcase
    end

    // State register; break_det is loaded from the next state so it tracks BREAK exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_OFF;
            r_break_det <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_break_det <= (w_state_nxt == c_ST_BREAK);
        end
    end

    // Break timer: counts consecutive low samples while staying in ACTIVE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else if (r_state != c_ST_ACTIVE || w_state_nxt != c_ST_ACTIVE || rx_line) begin
            r_tmr <= '0;
        end else if (r_tmr != c_TMR_MAX) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    assign w_accept  = frm_valid && (r_state == c_ST_ACTIVE);
    assign w_has_err = frm_parity_err || frm_stop_err;

    generate
        if (DROP_ERR != 0) begin : g_drop_err
            assign w_store  = w_accept && !w_has_err;
            assign w_wflags = '0;
        end else begin : g_keep_err
            assign w_store  = w_accept;
            assign w_wflags = {frm_stop_err, frm_parity_err};
        end
    endgenerate

    assign w_pop  = !w_empty && out_ready;
    assign w_lost = w_store && w_full && !w_pop;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_store),
        .i_pop   (w_pop),
        .i_wdata ({w_wflags, frm_data}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // Statistics: saturating counters and sticky overrun; a clear beats any increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pe_cnt  <= '0;
            r_se_cnt  <= '0;
            r_ov_cnt  <= '0;
            r_overrun <= 1'b0;
        end else if (clr_stats) begin
            r_pe_cnt  <= '0;
            r_se_cnt  <= '0;
            r_ov_cnt  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept && frm_parity_err && r_pe_cnt != c_CNT_MAX) r_pe_cnt <= r_pe_cnt + 1'b1;
            if (w_accept && frm_stop_err && r_se_cnt != c_CNT_MAX)   r_se_cnt <= r_se_cnt + 1'b1;
            if (w_lost && r_ov_cnt != c_CNT_MAX)                     r_ov_cnt <= r_ov_cnt + 1'b1;
            if (w_lost)                                              r_overrun <= 1'b1;
        end
    end

    assign out_valid      = !w_empty;
    assign out_data       = w_rdata[DATA_W-1:0];
    assign out_err        = w_rdata[DATA_W +: FLAG_W];
    assign overrun        = r_overrun;
    assign break_det      = r_break_det;
    assign parity_err_cnt = r_pe_cnt;
    assign stop_err_cnt   = r_se_cnt;
    assign overrun_cnt    = r_ov_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Directed self-checking bench. Two controllers share stimulus:
//            A uses defaults (DROP_ERR=1, CNT_W=8), B keeps errored frames
//            (DROP_ERR=0) with 2-bit counters to expose saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b0;
    logic       rx_line = 1'b1;
    logic       frm_valid = 1'b0;
    logic [7:0] frm_data = 8'h00;
    logic       frm_parity_err = 1'b0;
    logic       frm_stop_err = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_stats = 1'b0;

    logic       a_valid, a_ovr, a_brk;
    logic [7:0] a_data, a_pe, a_se, a_oc;
    logic [1:0] a_err;
    logic [2:0] a_level;

    logic       b_valid, b_ovr, b_brk;
    logic [7:0] b_data;
    logic [1:0] b_err, b_pe, b_se, b_oc;
    logic [2:0] b_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(4), .CNT_W(8), .BREAK_CYCLES(160), .DROP_ERR(1)) dut_a (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_line(rx_line),
        .frm_valid(frm_valid), .frm_data(frm_data),
        .frm_parity_err(frm_parity_err), .frm_stop_err(frm_stop_err),
        .out_valid(a_valid), .out_data(a_data), .out_err(a_err), .out_ready(out_ready),
        .clr_stats(clr_stats), .fifo_level(a_level), .overrun(a_ovr), .break_det(a_brk),
        .parity_err_cnt(a_pe), .stop_err_cnt(a_se), .overrun_cnt(a_oc)
    );

    uart_rx_ctrl #(.DEPTH(4), .CNT_W(2), .BREAK_CYCLES(160), .DROP_ERR(0)) dut_b (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_line(rx_line),
        .frm_valid(frm_valid), .frm_data(frm_data),
        .frm_parity_err(frm_parity_err), .frm_stop_err(frm_stop_err),
        .out_valid(b_valid), .out_data(b_data), .out_err(b_err), .out_ready(out_ready),
        .clr_stats(clr_stats), .fifo_level(b_level), .overrun(b_ovr), .break_det(b_brk),
        .parity_err_cnt(b_pe), .stop_err_cnt(b_se), .overrun_cnt(b_oc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic se);
        frm_data = d; frm_parity_err = pe; frm_stop_err = se; frm_valid = 1'b1;
        tick();
        frm_valid = 1'b0; frm_parity_err = 1'b0; frm_stop_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; rx_en = 1'b0; rx_line = 1'b1; frm_valid = 1'b0;
        out_ready = 1'b0; clr_stats = 1'b0; frm_parity_err = 1'b0; frm_stop_err = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic enable();
        rx_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        n_checks++; if ({a_valid, a_data, a_err, a_level, a_ovr, a_brk, a_pe, a_se, a_oc} !== '0) begin n_fail++;
            $display("FAIL reset_a: got v=%b d=%h e=%b lvl=%0d ov=%b brk=%b cnt=%h/%h/%h, want all 0", a_valid, a_data, a_err, a_level, a_ovr, a_brk, a_pe, a_se, a_oc); end
        n_checks++; if ({b_valid, b_data, b_err, b_level, b_ovr, b_brk, b_pe, b_se, b_oc} !== '0) begin n_fail++;
            $display("FAIL reset_b: got v=%b d=%h e=%b lvl=%0d ov=%b brk=%b, want all 0", b_valid, b_data, b_err, b_level, b_ovr, b_brk); end
        tick();
        rst = 1'b1;
        send(8'h99, 1'b0, 1'b0);
        n_checks++; if ({a_valid, a_level} !== 4'b0) begin n_fail++;
            $display("FAIL off_ignore: got v=%b lvl=%0d, want v=0 lvl=0", a_valid, a_level); end
    endtask

    task automatic test_basic();
        do_reset(); enable();
        out_ready = 1'b1;
        send(8'h41, 1'b0, 1'b0);
        n_checks++; if ({a_valid, a_data} !== {1'b1, 8'h41}) begin n_fail++;
            $display("FAIL basic_first: got v=%b d=%h, want v=1 d=41", a_valid, a_data); end
        send(8'h42, 1'b0, 1'b0);
        n_checks++; if ({a_valid, a_data, a_level} !== {1'b1, 8'h42, 3'd1}) begin n_fail++;
            $display("FAIL basic_second: got v=%b d=%h lvl=%0d, want v=1 d=42 lvl=1", a_valid, a_data, a_level); end
        tick();
        n_checks++; if ({a_valid, a_level} !== 4'b0) begin n_fail++;
            $display("FAIL basic_drained: got v=%b lvl=%0d, want 0/0", a_valid, a_level); end
        n_checks++; if ({a_pe, a_se, a_oc, a_ovr} !== '0) begin n_fail++;
            $display("FAIL basic_counters: got %h/%h/%h ov=%b, want 0", a_pe, a_se, a_oc, a_ovr); end
        out_ready = 1'b0;
    endtask

    task automatic test_errors();
        do_reset(); enable();
        send(8'h55, 1'b1, 1'b0);
        send(8'h66, 1'b1, 1'b1);
        n_checks++; if ({a_valid, a_level} !== 4'b0) begin n_fail++;
            $display("FAIL err_drop_a: got v=%b lvl=%0d, want 0/0", a_valid, a_level); end
        n_checks++; if ({a_pe, a_se} !== {8'd2, 8'd1}) begin n_fail++;
            $display("FAIL err_counts_a: got pe=%0d se=%0d, want pe=2 se=1", a_pe, a_se); end
        n_checks++; if ({b_level, b_data, b_err, b_pe, b_se} !== {3'd2, 8'h55, 2'b01, 2'd2, 2'd1}) begin n_fail++;
            $display("FAIL err_keep_b_head: got lvl=%0d d=%h e=%b pe=%0d se=%0d, want 2 55 01 2 1", b_level, b_data, b_err, b_pe, b_se); end
        out_ready = 1'b1;
        tick();
        n_checks++; if ({b_valid, b_data, b_err} !== {1'b1, 8'h66, 2'b11}) begin n_fail++;
            $display("FAIL err_keep_b_second: got v=%b d=%h e=%b, want 1 66 11", b_valid, b_data, b_err); end
        tick();
        n_checks++; if ({b_valid, a_err} !== 3'b0) begin n_fail++;
            $display("FAIL err_b_drained: got b_v=%b a_err=%b, want 0/00", b_valid, a_err); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset(); enable();
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0, 1'b0);
        n_checks++; if ({a_level, a_ovr, a_oc} !== {3'd4, 1'b1, 8'd2}) begin n_fail++;
            $display("FAIL ovf_a: got lvl=%0d ov=%b oc=%0d, want 4 1 2", a_level, a_ovr, a_oc); end
        n_checks++; if ({b_level, b_ovr, b_oc} !== {3'd4, 1'b1, 2'd2}) begin n_fail++;
            $display("FAIL ovf_b: got lvl=%0d ov=%b oc=%0d, want 4 1 2", b_level, b_ovr, b_oc); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if ({a_valid, a_data} !== {1'b1, 8'(i)}) begin n_fail++;
                $display("FAIL ovf_drain_%0d: got v=%b d=%h, want v=1 d=%h", i, a_valid, a_data, 8'(i)); end
            tick();
        end
        n_checks++; if ({a_valid, a_level} !== 4'b0) begin n_fail++;
            $display("FAIL ovf_empty: got v=%b lvl=%0d, want 0/0", a_valid, a_level); end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h11 + i), 1'b0, 1'b0);
        frm_data = 8'h15; frm_valid = 1'b1; out_ready = 1'b1;
        tick();
        frm_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if ({a_level, a_data, a_ovr, a_oc} !== {3'd4, 8'h12, 1'b1, 8'd2}) begin n_fail++;
            $display("FAIL ovf_push_pop_full: got lvl=%0d d=%h ov=%b oc=%0d, want 4 12 1 2", a_level, a_data, a_ovr, a_oc); end
    endtask

    task automatic test_break();
        do_reset(); enable();
        out_ready = 1'b1;
        rx_line = 1'b0;
        repeat (160) tick();
        n_checks++; if (a_brk !== 1'b0) begin n_fail++;
            $display("FAIL brk_not_yet: got %b, want 0", a_brk); end
        tick();
        n_checks++; if ({a_brk, b_brk} !== 2'b11) begin n_fail++;
            $display("FAIL brk_set: got a=%b b=%b, want 1 1", a_brk, b_brk); end
        send(8'h77, 1'b1, 1'b0);
        n_checks++; if ({a_valid, a_level, a_brk, a_pe} !== {1'b0, 3'd0, 1'b1, 8'd0}) begin n_fail++;
            $display("FAIL brk_ignore: got v=%b lvl=%0d brk=%b pe=%0d, want 0 0 1 0", a_valid, a_level, a_brk, a_pe); end
        rx_line = 1'b1;
        tick();
        n_checks++; if (a_brk !== 1'b0) begin n_fail++;
            $display("FAIL brk_exit: got %b, want 0", a_brk); end
        send(8'h78, 1'b0, 1'b0);
        n_checks++; if ({a_valid, a_data} !== {1'b1, 8'h78}) begin n_fail++;
            $display("FAIL brk_active_again: got v=%b d=%h, want 1 78", a_valid, a_data); end
        tick();
        rx_line = 1'b0;
        repeat (159) tick();
        rx_line = 1'b1;
        tick();
        rx_line = 1'b0;
        repeat (5) tick();
        n_checks++; if (a_brk !== 1'b0) begin n_fail++;
            $display("FAIL brk_159_short: got %b, want 0", a_brk); end
        rx_line = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_enable_sat();
        do_reset(); enable();
        send(8'h21, 1'b0, 1'b0);
        rx_en = 1'b0;
        tick();
        send(8'h22, 1'b0, 1'b0);
        send(8'h23, 1'b1, 1'b0);
        n_checks++; if ({a_valid, a_data, a_level, a_pe, b_pe} !== {1'b1, 8'h21, 3'd1, 8'd0, 2'd0}) begin n_fail++;
            $display("FAIL en_off_ignore: got v=%b d=%h lvl=%0d pe=%0d/%0d, want 1 21 1 0 0", a_valid, a_data, a_level, a_pe, b_pe); end
        out_ready = 1'b1;
        tick();
        n_checks++; if ({a_valid, a_level} !== 4'b0) begin n_fail++;
            $display("FAIL en_drain_off: got v=%b lvl=%0d, want 0/0", a_valid, a_level); end
        out_ready = 1'b0;
        rx_en = 1'b1;
        tick();
        repeat (5) send(8'h30, 1'b1, 1'b0);
        n_checks++; if ({a_pe, b_pe, b_oc, b_ovr, b_level} !== {8'd5, 2'd3, 2'd1, 1'b1, 3'd4}) begin n_fail++;
            $display("FAIL sat_counts: got a_pe=%0d b_pe=%0d b_oc=%0d b_ov=%b b_lvl=%0d, want 5 3 1 1 4", a_pe, b_pe, b_oc, b_ovr, b_level); end
        clr_stats = 1'b1;
        send(8'h31, 1'b1, 1'b0);
        clr_stats = 1'b0;
        n_checks++; if ({a_pe, a_oc, b_pe, b_oc, b_ovr} !== '0) begin n_fail++;
            $display("FAIL clr_wins: got a_pe=%0d a_oc=%0d b_pe=%0d b_oc=%0d b_ov=%b, want all 0", a_pe, a_oc, b_pe, b_oc, b_ovr); end
    endtask

    task automatic test_async_reset();
        do_reset(); enable();
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b1, 1'b0);
        send(8'hA3, 1'b0, 1'b0);
        rx_line = 1'b0;
        repeat (161) tick();
        n_checks++; if ({a_level, b_level, a_brk, a_pe} !== {3'd2, 3'd3, 1'b1, 8'd1}) begin n_fail++;
            $display("FAIL ar_setup: got a_lvl=%0d b_lvl=%0d brk=%b pe=%0d, want 2 3 1 1", a_level, b_level, a_brk, a_pe); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({a_valid, a_data, a_err, a_level, a_ovr, a_brk, a_pe, a_se, a_oc} !== '0) begin n_fail++;
            $display("FAIL ar_async_a: got v=%b d=%h lvl=%0d brk=%b pe=%0d, want all 0", a_valid, a_data, a_level, a_brk, a_pe); end
        n_checks++; if ({b_valid, b_data, b_err, b_level, b_ovr, b_brk, b_pe, b_se, b_oc} !== '0) begin n_fail++;
            $display("FAIL ar_async_b: got v=%b d=%h e=%b lvl=%0d brk=%b, want all 0", b_valid, b_data, b_err, b_level, b_brk); end
        tick();
        rst = 1'b1; rx_en = 1'b1; rx_line = 1'b1;
        frm_data = 8'hB1; frm_valid = 1'b1;
        tick();
        frm_data = 8'hB2;
        tick();
        frm_valid = 1'b0;
        n_checks++; if ({a_valid, a_data, a_level} !== {1'b1, 8'hB2, 3'd1}) begin n_fail++;
            $display("FAIL ar_active_next_edge: got v=%b d=%h lvl=%0d, want 1 B2 1", a_valid, a_data, a_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_overflow();
        test_break();
        test_enable_sat();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
